pll_cfg_responder: RTL

PLL_CFG_RESPONDER -- requirements
Module: pll_cfg_responder

---
 rtl/pll_cfg_pkg.sv | 45 ++++
 rtl/cfg_delay_cnt.sv | 28 ++
 rtl/pll_cfg_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration register responder.
// Holds the register word map, the power-on PLL settings and the FSM state type.
// Contents: ADDR_* map, RST_* values, cfg_t register set, state_t, c_index_ok().
package pll_cfg_pkg;

   localparam logic [5:0] ADDR_MODE   = 6'd0;
   localparam logic [5:0] ADDR_STATUS = 6'd1;
   localparam logic [5:0] ADDR_START  = 6'd2;
   localparam logic [5:0] ADDR_N      = 6'd3;
   localparam logic [5:0] ADDR_M      = 6'd4;
   localparam logic [5:0] ADDR_C      = 6'd5;
   localparam logic [5:0] ADDR_K      = 6'd7;
   localparam logic [5:0] ADDR_BW     = 6'd8;
   localparam logic [5:0] ADDR_CP     = 6'd9;

   localparam logic [31:0] RST_MODE = 32'h0000_0000;
   localparam logic [31:0] RST_N    = 32'h0001_0000;
   localparam logic [31:0] RST_M    = 32'h0000_0160;
   localparam logic [31:0] RST_C0   = 32'h0002_0302;
   localparam logic [31:0] RST_K    = 32'h0000_0001;
   localparam logic [31:0] RST_BW   = 32'h0000_0007;
   localparam logic [31:0] RST_CP   = 32'h0000_0001;

   typedef enum logic [1:0] {IDLE, RD_WAIT, APPLY, RELOCK} state_t;

   // One full PLL setting; used for both the shadow and the committed copy.
   typedef struct packed {
      logic [31:0] mode;
      logic [31:0] n;
      logic [31:0] m;
      logic [31:0] c0;
      logic [31:0] k;
      logic [31:0] bw;
      logic [31:0] cp;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{mode: RST_MODE, n: RST_N, m: RST_M, c0: RST_C0,
                                  k: RST_K, bw: RST_BW, cp: RST_CP};

   // Only counter C0 exists in this model; the index lives in writedata[22:18].
   function automatic logic c_index_ok(input logic [4:0] idx);
      return (idx == 5'd0);
   endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Reloadable down-counter shared by the apply-wait and relock timers.
// Latency: done is high once the count reaches zero; load takes effect next edge.
// Ports: CLK_50M/RESET, load + load_val (reload), done (count is zero, holds there).
module cfg_delay_cnt #(
   parameter int            W         = 16,
   parameter logic [W-1:0]  RESET_VAL = '0
) (
   input  logic         CLK_50M,
   input  logic         RESET,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK_50M) begin
      if (RESET)
         cnt <= RESET_VAL;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/pll_cfg_responder.sv
// Behavioural PLL reconfiguration slave: shadow registers, start-triggered apply, relock model.
// Latency: writes accepted at once in IDLE/RELOCK; reads take one wait cycle; start stalls APPLY_CYCLES.
// Backpressure: mgmt_waitrequest; requests seen while it is high are dropped, master must hold them.
// Ports: mgmt_* register bus, locked, act_* committed settings, apply_cnt, sticky err.
module pll_cfg_responder
   import pll_cfg_pkg::*;
#(
   parameter int APPLY_CYCLES = 16,
   parameter int LOCK_CYCLES  = 64
) (
   input  logic        CLK_50M,
   input  logic        RESET,
   input  logic [5:0]  mgmt_address,
   input  logic        mgmt_write,
   input  logic        mgmt_read,
   input  logic [31:0] mgmt_writedata,
   output logic [31:0] mgmt_readdata,
   output logic        mgmt_waitrequest,
   output logic        locked,
   output logic [31:0] act_m,
   output logic [31:0] act_n,
   output logic [31:0] act_c0,
   output logic [31:0] act_k,
   output logic [31:0] act_bw,
   output logic [31:0] act_cp,
   output logic [15:0] apply_cnt,
   output logic        err
);

   // The counter is loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [15:0] APPLY_LD = 16'(APPLY_CYCLES - 1);
   localparam logic [15:0] LOCK_LD  = 16'(LOCK_CYCLES - 1);

   state_t      state, state_nxt;
   cfg_t        shadow, act;
   logic        cnt_load, cnt_done;
   logic [15:0] cnt_val;
   logic        wr_acc, start, commit, busy, bad_addr;
   logic [31:0] rd_mux;

   cfg_delay_cnt #(.W(16), .RESET_VAL(LOCK_LD)) u_delay (
      .CLK_50M  (CLK_50M),
      .RESET    (RESET),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   assign busy   = (state == APPLY) || (state == RELOCK);
   assign wr_acc = mgmt_write && ((state == IDLE) || (state == RELOCK));
   assign start  = wr_acc && (mgmt_address == ADDR_START);
   assign commit = (state == APPLY) && cnt_done;

   always_comb begin
      state_nxt        = state;
      mgmt_waitrequest = 1'b0;
      cnt_load         = 1'b0;
      cnt_val          = APPLY_LD;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = APPLY;
               cnt_load  = 1'b1;
            end else if (mgmt_read && !mgmt_write) begin
               // A read alongside a write is dropped, so only a lone read stalls.
               mgmt_waitrequest = 1'b1;
               state_nxt        = RD_WAIT;
            end
         end
         RD_WAIT: state_nxt = IDLE;
         APPLY: begin
            mgmt_waitrequest = 1'b1;
            if (cnt_done) begin
               state_nxt = RELOCK;
               cnt_load  = 1'b1;
               cnt_val   = LOCK_LD;
            end
         end
         RELOCK: begin
            // A fresh start outranks lock completion in the same cycle.
            if (start) begin
               state_nxt = APPLY;
               cnt_load  = 1'b1;
            end else if (cnt_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bad_addr = 1'b0;
      case (mgmt_address)
         ADDR_MODE, ADDR_START, ADDR_N, ADDR_M,
         ADDR_K, ADDR_BW, ADDR_CP: bad_addr = 1'b0;
         ADDR_C:                   bad_addr = !c_index_ok(mgmt_writedata[22:18]);
         default:                  bad_addr = 1'b1;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (mgmt_address)
         ADDR_MODE:   rd_mux = shadow.mode;
         ADDR_STATUS: rd_mux = {30'b0, locked, busy};
         ADDR_N:      rd_mux = shadow.n;
         ADDR_M:      rd_mux = shadow.m;
         ADDR_C:      rd_mux = shadow.c0;
         ADDR_K:      rd_mux = shadow.k;
         ADDR_BW:     rd_mux = shadow.bw;
         ADDR_CP:     rd_mux = shadow.cp;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK_50M) begin
      if (RESET) begin
         state         <= RELOCK;
         shadow        <= CFG_RESET;
         act           <= CFG_RESET;
         apply_cnt     <= '0;
         err           <= 1'b0;
         locked        <= 1'b0;
         mgmt_readdata <= '0;
      end else begin
         state <= state_nxt;
         if (wr_acc) begin
            case (mgmt_address)
               ADDR_MODE: shadow.mode <= mgmt_writedata;
               ADDR_N:    shadow.n    <= mgmt_writedata;
               ADDR_M:    shadow.m    <= mgmt_writedata;
               ADDR_C:    if (!bad_addr) shadow.c0 <= mgmt_writedata;
               ADDR_K:    shadow.k    <= mgmt_writedata;
               ADDR_BW:   shadow.bw   <= mgmt_writedata;
               ADDR_CP:   shadow.cp   <= mgmt_writedata;
               default:   ;
            endcase
            if (bad_addr || mgmt_read)
               err <= 1'b1;
         end
         if (commit) begin
            act       <= shadow;
            apply_cnt <= apply_cnt + 16'd1;
         end
         if (start)
            locked <= 1'b0;
         else if ((state == RELOCK) && cnt_done)
            locked <= 1'b1;
         if ((state == IDLE) && mgmt_read && !mgmt_write)
            mgmt_readdata <= rd_mux;
      end
   end

   assign act_m  = act.m;
   assign act_n  = act.n;
   assign act_c0 = act.c0;
   assign act_k  = act.k;
   assign act_bw = act.bw;
   assign act_cp = act.cp;

endmodule
